shape_stats_unit: RTL and testbench
===================================

# shape_stats_unit

Synthesizable, streaming successor to the shape-reporting flow. The block accepts shape records (type, width, height) over a valid/ready handshake and computes each shape's area in a 2-stage pipeline. It keeps a per-type count and area sum. On request, it drains the pipeline and streams one report record per shape type in type order, optionally clearing the statistics. It sits between the record source (file loader or bus adapter) and the report sink.

## Interface
Parameters:
- DIM_W, 16: width and height bit-width (unsigned)
- CNT_W, 16: per-type shape counter width
- ACC_W, 40: per-type area accumulator width; must be ≥ 2*DIM_W

Ports:
- clk  in  1  single clock; all logic is on the rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input record valid
- in_ready  out  1  block accepts a record
- in_type  in  2  shape_pkg::shape_t code
- in_w  in  DIM_W  width
- in_h  in  DIM_W  height
- rep_req  in  1  start-report pulse
- rep_clear  in  1  sampled with rep_req; when 1, the statistics are cleared after the report
- rep_valid  out  1  report record valid
- rep_ready  in  1  sink accepts the report record
- rep_type  out  2  type of the current record
- rep_count  out  CNT_W  shapes of that type
- rep_area  out  ACC_W  summed area of that type
- rep_done  out  1  one-cycle pulse after the last record is accepted
- err_count  out  CNT_W  rejected records (live)

## Operation
- Codes: RECTANGLE=0, SQUARE=1, TRIANGLE=2, INVALID=3.
- Areas:
  - rectangle: w*h
  - square: w*w; a square with w≠h is rejected
  - triangle: (w*h)>>1, truncated
  - All products are 2*DIM_W bits, zero-extended to ACC_W.
- Rejected records: INVALID code, or a square with w≠h. A rejected record increments err_count and does not touch the per-type statistics.
- Pipeline:
  - S0 handshake (in_valid & in_ready).
  - S1 registers the product and the type/error flag.
  - S2 adds into the accumulator and increments the counter.
- Counter and accumulator overflow: wrap modulo 2^CNT_W / 2^ACC_W (see Configuration).
- FSM states:
  - IDLE: in_ready=1. rep_req moves to DRAIN and latches rep_clear.
  - DRAIN: in_ready=0. Wait until S1 and S2 are empty (always 2 cycles), then go to REPORT with index 0.
  - REPORT: rep_valid=1 with the data for the current index. On rep_valid & rep_ready, increment the index. After index 2 is accepted, go to DONE.
  - DONE: rep_done=1 for one cycle. If the clear flag is latched, zero the counters, accumulators and err_count. Return to IDLE.
- Boundary cases:
  - rep_req in the same IDLE cycle as an accepted record: the record is included in the report.
  - rep_req outside IDLE: ignored.
  - rep_ready held low: the record is held stable, with no timeout.
  - rst at any time (mid-pipeline, mid-report): immediate return to IDLE, all statistics zeroed, no rep_done.

## Timing
- Reset values:
  - in_ready=1
  - rep_valid=0, rep_done=0
  - rep_type=0, rep_count=0, rep_area=0
  - err_count=0
- A record accepted at edge N is visible in the statistics after edge N+2.
- err_count updates at edge N+2.
- rep_req sampled at edge N, with rep_ready held high:
  - in_ready=0 from N+1
  - first rep_valid at N+3
  - three records on consecutive cycles
  - rep_done at N+6
  - in_ready=1 at N+7
- rep_count, rep_area and rep_type are registered and change only after a handshake or on entering REPORT.

## Configuration
- SHAPE_STATS_SATURATE_EN:
  - Defined: counters, accumulators and err_count saturate at all-ones.
  - Undefined: they wrap.
  - No other behaviour changes.

## Structure
- shape_pkg holds:
  - shape_t enum (2 bits)
  - N_SHAPE_TYPES=3
  - the report FSM state enum
- Sub-module shape_area_calc contains stage S1 (type decode, multiply, halve, reject flag), registered output.
- shape_stats_unit contains the handshake, S2 accumulation, statistics arrays and the FSM.

## Test plan
- Load RECT 3×4, SQUARE 5×5, TRIANGLE 3×5, then report -> (0,1,12), (1,1,25), (2,1,7); err_count=0.
- SQUARE 4×5 and code 3 with 1×1 -> err_count=2; all counts and areas 0.
- Report with rep_clear=1, then a second report -> all records (t,0,0); err_count=0. With rep_clear=0, the values repeat.
- rep_req in the same cycle as RECT 2×2 -> report includes count 1, area 4; rep_ready toggling 1/0 keeps the data stable while rep_ready=0.
- DIM_W=4, CNT_W=2: five RECT 15×15 -> wrap build: count 1, area 1125; SHAPE_STATS_SATURATE_EN build: count 3.
- rst asserted during REPORT at index 1 -> all outputs at reset values next cycle, no rep_done; a following report gives all zeros.

Source files
------------

// File: rtl/shape_pkg.sv
// Shared types for the shape statistics block: shape codes,
// number of reported types and the report FSM states.
package shape_pkg;

    typedef enum logic [1:0] {
        RECTANGLE = 2'd0,
        SQUARE    = 2'd1,
        TRIANGLE  = 2'd2,
        INVALID   = 2'd3
    } shape_t;

    localparam int N_SHAPE_TYPES = 3;
    localparam logic [1:0] LAST_IDX = 2'(N_SHAPE_TYPES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_REPORT,
        ST_DONE
    } rep_state_t;

endpackage

// File: rtl/shape_area_calc.sv
// Stage S1: decodes the shape code, computes the area and the
// reject flag, and registers the result for accumulation.
module shape_area_calc
    import shape_pkg::*;
#(
    parameter int DIM_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_i,
    input  logic [1:0]         type_i,
    input  logic [DIM_W-1:0]   w_i,
    input  logic [DIM_W-1:0]   h_i,
    output logic               valid_o,
    output logic [1:0]         type_o,
    output logic               err_o,
    output logic [2*DIM_W-1:0] area_o
);

    localparam int PW = 2 * DIM_W;

    logic [PW-1:0] wh;
    logic [PW-1:0] ww;
    logic [PW-1:0] area_d;
    logic          err_d;

    logic          valid_q;
    logic [1:0]    type_q;
    logic          err_q;
    logic [PW-1:0] area_q;

    assign wh = PW'(w_i) * PW'(h_i);
    assign ww = PW'(w_i) * PW'(w_i);

    always_comb begin
        area_d = '0;
        err_d  = 1'b0;
        unique case (1'b1)
            (type_i == RECTANGLE): area_d = wh;
            (type_i == SQUARE): begin
                area_d = ww;
                err_d  = (w_i != h_i);
            end
            (type_i == TRIANGLE): area_d = wh >> 1;
            default: err_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            type_q  <= 2'd0;
            err_q   <= 1'b0;
            area_q  <= '0;
        end else begin
            valid_q <= valid_i;
            if (valid_i) begin
                type_q <= type_i;
                err_q  <= err_d;
                area_q <= area_d;
            end
        end
    end

    assign valid_o = valid_q;
    assign type_o  = type_q;
    assign err_o   = err_q;
    assign area_o  = area_q;

endmodule

// File: rtl/shape_stats_unit.sv
// Streaming shape statistics with per-type count/area and a report FSM.
// Define SHAPE_STATS_SATURATE_EN to saturate counters instead of wrapping.
module shape_stats_unit
    import shape_pkg::*;
#(
    parameter int DIM_W = 16,
    parameter int CNT_W = 16,
    parameter int ACC_W = 40
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_type,
    input  logic [DIM_W-1:0] in_w,
    input  logic [DIM_W-1:0] in_h,
    input  logic             rep_req,
    input  logic             rep_clear,
    output logic             rep_valid,
    input  logic             rep_ready,
    output logic [1:0]       rep_type,
    output logic [CNT_W-1:0] rep_count,
    output logic [ACC_W-1:0] rep_area,
    output logic             rep_done,
    output logic [CNT_W-1:0] err_count
);

    logic             fire;
    logic             s0_valid_q;
    logic [1:0]       s0_type_q;
    logic [DIM_W-1:0] s0_w_q;
    logic [DIM_W-1:0] s0_h_q;

    logic               s1_valid;
    logic [1:0]         s1_type;
    logic               s1_err;
    logic [2*DIM_W-1:0] s1_area;
    logic [ACC_W-1:0]   s1_area_ext;

    logic [CNT_W-1:0] cnt_q [N_SHAPE_TYPES];
    logic [CNT_W-1:0] cnt_d [N_SHAPE_TYPES];
    logic [ACC_W-1:0] acc_q [N_SHAPE_TYPES];
    logic [ACC_W-1:0] acc_d [N_SHAPE_TYPES];
    logic [CNT_W-1:0] err_q;
    logic [CNT_W-1:0] err_d;
    logic             clear_now;

    rep_state_t       state_q;
    logic             rdy_q;
    logic             clr_q;
    logic             drain_q;
    logic [1:0]       idx_q;
    logic [1:0]       nidx;
    logic             rv_q;
    logic             rd_q;
    logic [1:0]       rt_q;
    logic [CNT_W-1:0] rc_q;
    logic [ACC_W-1:0] ra_q;

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
`ifdef SHAPE_STATS_SATURATE_EN
        cnt_inc = (&v) ? v : v + CNT_W'(1);
`else
        cnt_inc = v + CNT_W'(1);
`endif
    endfunction

    function automatic logic [ACC_W-1:0] acc_add(
        input logic [ACC_W-1:0] a,
        input logic [ACC_W-1:0] b
    );
`ifdef SHAPE_STATS_SATURATE_EN
        logic [ACC_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        acc_add = s[ACC_W] ? '1 : s[ACC_W-1:0];
`else
        acc_add = a + b;
`endif
    endfunction

    assign fire = in_valid & rdy_q;

    // S0: capture the accepted record
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_valid_q <= 1'b0;
            s0_type_q  <= 2'd0;
            s0_w_q     <= '0;
            s0_h_q     <= '0;
        end else begin
            s0_valid_q <= fire;
            if (fire) begin
                s0_type_q <= in_type;
                s0_w_q    <= in_w;
                s0_h_q    <= in_h;
            end
        end
    end

    shape_area_calc #(
        .DIM_W (DIM_W)
    ) u_calc (
        .clk     (clk),
        .rst     (rst),
        .valid_i (s0_valid_q),
        .type_i  (s0_type_q),
        .w_i     (s0_w_q),
        .h_i     (s0_h_q),
        .valid_o (s1_valid),
        .type_o  (s1_type),
        .err_o   (s1_err),
        .area_o  (s1_area)
    );

    assign s1_area_ext = ACC_W'(s1_area);
    assign clear_now   = (state_q == ST_DONE) && clr_q;

    // S2: next-state statistics; also feeds the first report word
    always_comb begin
        for (int i = 0; i < N_SHAPE_TYPES; i++) begin
            cnt_d[i] = cnt_q[i];
            acc_d[i] = acc_q[i];
        end
        err_d = err_q;
        if (s1_valid) begin
            if (s1_err) begin
                err_d = cnt_inc(err_q);
            end else begin
                for (int i = 0; i < N_SHAPE_TYPES; i++) begin
                    if (s1_type == 2'(i)) begin
                        cnt_d[i] = cnt_inc(cnt_q[i]);
                        acc_d[i] = acc_add(acc_q[i], s1_area_ext);
                    end
                end
            end
        end
        if (clear_now) begin
            for (int i = 0; i < N_SHAPE_TYPES; i++) begin
                cnt_d[i] = '0;
                acc_d[i] = '0;
            end
            err_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_SHAPE_TYPES; i++) begin
                cnt_q[i] <= '0;
                acc_q[i] <= '0;
            end
            err_q <= '0;
        end else begin
            for (int i = 0; i < N_SHAPE_TYPES; i++) begin
                cnt_q[i] <= cnt_d[i];
                acc_q[i] <= acc_d[i];
            end
            err_q <= err_d;
        end
    end

    assign nidx = idx_q + 2'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rdy_q   <= 1'b1;
            clr_q   <= 1'b0;
            drain_q <= 1'b0;
            idx_q   <= 2'd0;
            rv_q    <= 1'b0;
            rd_q    <= 1'b0;
            rt_q    <= 2'd0;
            rc_q    <= '0;
            ra_q    <= '0;
        end else begin
            rd_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (rep_req) begin
                        state_q <= ST_DRAIN;
                        clr_q   <= rep_clear;
                        rdy_q   <= 1'b0;
                        drain_q <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    // S0 and S1 are empty two cycles after intake stops
                    if (drain_q) begin
                        state_q <= ST_REPORT;
                        idx_q   <= 2'd0;
                        rv_q    <= 1'b1;
                        rt_q    <= 2'd0;
                        rc_q    <= cnt_d[0];
                        ra_q    <= acc_d[0];
                    end else begin
                        drain_q <= 1'b1;
                    end
                end
                ST_REPORT: begin
                    if (rep_ready) begin
                        if (idx_q == LAST_IDX) begin
                            state_q <= ST_DONE;
                            rv_q    <= 1'b0;
                            rd_q    <= 1'b1;
                        end else begin
                            idx_q <= nidx;
                            rt_q  <= nidx;
                            rc_q  <= cnt_q[nidx];
                            ra_q  <= acc_q[nidx];
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    rdy_q   <= 1'b1;
                    clr_q   <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = rdy_q;
    assign rep_valid = rv_q;
    assign rep_done  = rd_q;
    assign rep_type  = rt_q;
    assign rep_count = rc_q;
    assign rep_area  = ra_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_shape_stats_unit.sv
// Scoreboard bench for shape_stats_unit (small widths so counters wrap).
// Build with SHAPE_STATS_SATURATE_EN to check the saturating variant.
module tb_shape_stats_unit;

    localparam int DW = 4;
    localparam int CW = 2;
    localparam int AW = 16;
    localparam int CMAX = (1 << CW) - 1;
    localparam int AMAX = (1 << AW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    in_type = 2'd0;
    logic [DW-1:0] in_w = '0;
    logic [DW-1:0] in_h = '0;
    logic          rep_req = 1'b0;
    logic          rep_clear = 1'b0;
    logic          rep_valid;
    logic          rep_ready = 1'b1;
    logic [1:0]    rep_type;
    logic [CW-1:0] rep_count;
    logic [AW-1:0] rep_area;
    logic          rep_done;
    logic [CW-1:0] err_count;

    shape_stats_unit #(
        .DIM_W (DW),
        .CNT_W (CW),
        .ACC_W (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_type   (in_type),
        .in_w      (in_w),
        .in_h      (in_h),
        .rep_req   (rep_req),
        .rep_clear (rep_clear),
        .rep_valid (rep_valid),
        .rep_ready (rep_ready),
        .rep_type  (rep_type),
        .rep_count (rep_count),
        .rep_area  (rep_area),
        .rep_done  (rep_done),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int t;
        int c;
        int a;
    } rec_t;

    rec_t exp_q[$];
    int   m_cnt[3];
    int   m_area[3];
    int   m_err;
    int   n_tests = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int inc_c(input int v);
`ifdef SHAPE_STATS_SATURATE_EN
        return (v == CMAX) ? v : v + 1;
`else
        return (v + 1) & CMAX;
`endif
    endfunction

    function automatic int add_a(input int v, input int a);
`ifdef SHAPE_STATS_SATURATE_EN
        return (v + a > AMAX) ? AMAX : v + a;
`else
        return (v + a) & AMAX;
`endif
    endfunction

    task automatic model_apply(input int t, input int w, input int h);
        int a;
        if (t == 3 || (t == 1 && w != h)) begin
            m_err = inc_c(m_err);
        end else begin
            a = (t == 2) ? (w * h) / 2 : w * h;
            m_cnt[t]  = inc_c(m_cnt[t]);
            m_area[t] = add_a(m_area[t], a);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            m_cnt[i]  = 0;
            m_area[i] = 0;
        end
        m_err = 0;
    endtask

    task automatic send(input int t, input int w, input int h);
        in_valid = 1'b1;
        in_type  = 2'(t);
        in_w     = DW'(w);
        in_h     = DW'(h);
        model_apply(t, w, h);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; a record may already be driven on in_*.
    task automatic run_report(input logic clr, input logic tgl, input logic timed);
        int   j;
        int   first_v;
        int   done_at;
        rec_t e;
        for (int i = 0; i < 3; i++) begin
            e.t = i;
            e.c = m_cnt[i];
            e.a = m_area[i];
            exp_q.push_back(e);
        end
        if (clr) model_clear();
        rep_req   = 1'b1;
        rep_clear = clr;
        rep_ready = tgl ? 1'b0 : 1'b1;
        @(posedge clk);
        #1;
        rep_req   = 1'b0;
        rep_clear = 1'b0;
        in_valid  = 1'b0;
        first_v   = -1;
        done_at   = -1;
        j         = 0;
        while (j < 40) begin
            @(negedge clk);
            j++;
            if (timed && j == 1) chk("in_ready_drain", in_ready, 0);
            if (rep_valid && first_v < 0) first_v = j;
            if (rep_valid) begin
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else if (rep_ready) begin
                    e = exp_q.pop_front();
                    chk("rep_type", rep_type, e.t);
                    chk("rep_count", rep_count, e.c);
                    chk("rep_area", rep_area, e.a);
                end else begin
                    e = exp_q[0];
                    chk("stall_type", rep_type, e.t);
                    chk("stall_count", rep_count, e.c);
                    chk("stall_area", rep_area, e.a);
                end
            end
            if (rep_done) begin
                done_at = j;
                break;
            end
            @(posedge clk);
            #1;
            if (tgl) rep_ready = ~rep_ready;
        end
        if (done_at < 0) chk("rep_timeout", 0, 1);
        chk("sb_empty", exp_q.size(), 0);
        exp_q.delete();
        if (timed) begin
            chk("first_valid_cyc", first_v, 3);
            chk("done_cyc", done_at, 6);
        end
        @(posedge clk);
        #1;
        chk("in_ready_back", in_ready, 1);
        chk("rep_done_pulse", rep_done, 0);
        rep_ready = 1'b1;
    endtask

    initial begin
        int  j;
        logic seen_done;
        model_clear();
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_rep_valid", rep_valid, 0);
        chk("rst_rep_done", rep_done, 0);
        chk("rst_rep_type", rep_type, 0);
        chk("rst_rep_count", rep_count, 0);
        chk("rst_rep_area", rep_area, 0);
        chk("rst_err", err_count, 0);
        @(posedge clk);
        #1;

        // basic load: (0,1,12) (1,1,25) (2,1,7)
        send(0, 3, 4);
        send(1, 5, 5);
        send(2, 3, 5);
        idle(3);
        chk("err_basic", err_count, m_err);
        run_report(1'b0, 1'b0, 1'b1);
        run_report(1'b0, 1'b0, 1'b0);
        run_report(1'b1, 1'b0, 1'b0);
        run_report(1'b0, 1'b0, 1'b0);
        chk("err_after_clear", err_count, 0);

        // rejected records
        send(1, 4, 5);
        send(3, 1, 1);
        idle(3);
        chk("err_two", err_count, 2);
        chk("err_model", err_count, m_err);
        run_report(1'b1, 1'b0, 1'b0);
        chk("err_cleared", err_count, 0);

        // record accepted in the rep_req cycle, sink stalls every other cycle
        in_valid = 1'b1;
        in_type  = 2'd0;
        in_w     = DW'(2);
        in_h     = DW'(2);
        model_apply(0, 2, 2);
        run_report(1'b1, 1'b1, 1'b0);

        // counter overflow
        for (int i = 0; i < 5; i++) send(0, 15, 15);
        idle(3);
        run_report(1'b1, 1'b0, 1'b0);

        // reset in the middle of a report
        send(0, 1, 2);
        idle(3);
        rep_req   = 1'b1;
        rep_clear = 1'b0;
        rep_ready = 1'b1;
        @(posedge clk);
        #1 rep_req = 1'b0;
        j = 0;
        while (!rep_valid && j < 10) begin
            @(posedge clk);
            #1;
            j++;
        end
        chk("mid_idx0", rep_type, 0);
        @(posedge clk);
        #1;
        chk("mid_idx1", rep_type, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", rep_valid, 0);
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_type", rep_type, 0);
        chk("mid_rst_count", rep_count, 0);
        chk("mid_rst_area", rep_area, 0);
        chk("mid_rst_err", err_count, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            seen_done |= rep_done;
        end
        chk("mid_no_done", seen_done, 0);
        @(posedge clk);
        #1;
        model_clear();
        run_report(1'b0, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
